// File: rtl/demux4_hold.sv
// demux4_hold: 1-to-4 valid/ready demux with a one-word holding register per channel.
// Define DEMUX_BCAST_EN to add the in_bcast port for all-or-nothing broadcast to all four channels.
module demux4_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
`ifdef DEMUX_BCAST_EN
    input  logic             in_bcast,
`endif
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic             busy
);
    logic [3:0]       full_q;
    logic [3:0]       full_d;
    logic [3:0]       drain;
    logic [3:0]       free;
    logic [3:0]       load;
    logic [3:0]       sel_oh;
    logic             accept;
    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];

    // Handshake: a channel can take a word when empty or draining this cycle (pass-through refill)
    always_comb begin
        sel_oh = 4'b0001 << in_sel;
        drain  = full_q & out_ready;
        free   = ~full_q | drain;
`ifdef DEMUX_BCAST_EN
        in_ready = in_bcast ? &free : free[in_sel];
        accept   = in_valid & in_ready;
        load     = accept ? (in_bcast ? 4'b1111 : sel_oh) : 4'b0000;
`else
        in_ready = free[in_sel];
        accept   = in_valid & in_ready;
        load     = accept ? sel_oh : 4'b0000;
`endif
        full_d = (full_q & ~drain) | load;
        for (int k = 0; k < 4; k++) data_d[k] = load[k] ? in_data : data_q[k];
    end

    // Holding registers and full flags; reset discards any held words
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= '0;
            for (int k = 0; k < 4; k++) data_q[k] <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign out_valid = full_q;
    assign busy      = |full_q;
    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];
endmodule

// File: tb/tb_demux4_hold.sv
// tb_demux4_hold: randomized and directed checks of demux4_hold against a per-channel word-ledger model.
module tb_demux4_hold;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       in_valid = 0;
    logic       in_ready;
    logic [7:0] in_data = 0;
    logic [1:0] in_sel = 0;
    logic       bc = 0;
    logic [3:0] out_valid;
    logic [3:0] out_ready = 0;
    logic [7:0] out_data0, out_data1, out_data2, out_data3;
    logic       busy;

    int n_chk = 0;
    int n_fail = 0;
    int stalls;
    logic       acc;
    logic [3:0] mfull;
    logic [7:0] mdata [4];
    logic [7:0] tx [4][$];
    logic [7:0] dout [4];

    assign dout[0] = out_data0;
    assign dout[1] = out_data1;
    assign dout[2] = out_data2;
    assign dout[3] = out_data3;

    demux4_hold #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel),
`ifdef DEMUX_BCAST_EN
        .in_bcast(bc),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
    endtask

    // One cycle: compare DUT against the model mid-cycle, then advance the model across the edge
    task automatic step();
        logic [3:0] fr;
        logic [3:0] ld;
        logic       er;
        @(negedge clk);
        acc = 0;
        if (!rst_n) begin
            mfull = '0;
            for (int k = 0; k < 4; k++) begin
                mdata[k] = '0;
                tx[k].delete();
            end
        end else begin
            fr = ~mfull | out_ready;
            er = bc ? &fr : fr[in_sel];
            check("in_ready", {31'd0, in_ready}, {31'd0, er});
            check("out_valid", {28'd0, out_valid}, {28'd0, mfull});
            check("busy", {31'd0, busy}, {31'd0, |mfull});
            for (int k = 0; k < 4; k++) begin
                check($sformatf("out_data%0d", k), {24'd0, dout[k]}, {24'd0, mdata[k]});
                if (mfull[k] && out_ready[k])
                    check($sformatf("order_ch%0d", k), {24'd0, dout[k]}, {24'd0, tx[k].pop_front()});
            end
            acc = in_valid && er;
            ld = acc ? (bc ? 4'b1111 : 4'b0001 << in_sel) : 4'b0000;
            for (int k = 0; k < 4; k++)
                if (ld[k]) begin
                    mdata[k] = in_data;
                    tx[k].push_back(in_data);
                end
            mfull = (mfull & ~out_ready) | ld;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held two cycles with a word offered: nothing may load
        rst_n = 0;
        drive(1, 2, 8'hAB, 4'hF);
        step();
        step();
        rst_n = 1;
        drive(0, 0, 0, 0);
        step();
        // unicast A5 to channel 2
        drive(1, 2, 8'hA5, 4'h0);
        step();
        drive(0, 0, 0, 4'h0);
        step();
        // back-pressure: ch1 full and stalled blocks only ch1
        drive(1, 1, 8'h77, 4'h0);
        step();
        drive(1, 1, 8'h3C, 4'h0);
        step();
        drive(1, 0, 8'h11, 4'h0);
        step();
        // pass-through refill of ch3 while it drains
        drive(1, 3, 8'h01, 4'h0);
        step();
        drive(1, 3, 8'h02, 4'h8);
        step();
        drive(0, 0, 0, 4'h0);
        step();
        // streaming: one word per cycle, no stall
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1, 2'(i % 4), 8'(i), 4'hF);
            step();
            if (!acc) stalls++;
        end
        check("stream_stalls", stalls, 0);
        drive(0, 0, 0, 4'hF);
        step();
`ifdef DEMUX_BCAST_EN
        drive(1, 0, 8'h55, 4'h0);
        step();
        bc = 1;
        drive(1, 0, 8'hFF, 4'h0);
        step();
        drive(1, 0, 8'hFF, 4'h1);
        step();
        bc = 0;
        drive(0, 0, 0, 4'h0);
        step();
        drive(0, 0, 0, 4'hF);
        step();
`endif
        // mid-operation reset discards held words
        drive(1, 1, 8'h9E, 4'h0);
        step();
        rst_n = 0;
        drive(1, 3, 8'hC3, 4'h0);
        step();
        rst_n = 1;
        drive(0, 0, 0, 4'h0);
        step();
        // randomized traffic; upstream holds an offer until it is taken
        for (int i = 0; i < 400; i++) begin
            if (!(in_valid && !acc)) begin
                in_valid = $urandom_range(0, 3) != 0;
                in_sel   = 2'($urandom_range(0, 3));
                in_data  = 8'($urandom);
`ifdef DEMUX_BCAST_EN
                bc = $urandom_range(0, 7) == 0;
`endif
            end
            out_ready = 4'($urandom);
            step();
        end
        bc = 0;
        drive(0, 0, 0, 4'hF);
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
